pio_host_if: RTL

PIO_HOST_IF -- requirements
Module: pio_host_if

---
 rtl/pio_host_if.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pio_host_if.sv
// Host command interface for four PIO state machines: instruction memory, per-machine registers and TX/RX FIFOs.
// Defining PIO_HOST_READBACK_EN adds the action-15 register readback path onto dout.
module pio_host_if #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic [3:0]    action,
  input  logic [1:0]    mindex,
  input  logic [4:0]    index,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  input  logic [4:0]    imem_addr,
  output logic [15:0]   imem_data,
  output logic [127:0]  clkdiv,
  output logic [127:0]  pinctrl,
  output logic [3:0]    sm_en,
  output logic [3:0]    sm_restart,
  input  logic [3:0]    tx_pull,
  output logic [127:0]  tx_data,
  output logic [3:0]    tx_full,
  output logic [3:0]    tx_empty,
  input  logic [3:0]    rx_push,
  input  logic [127:0]  rx_data,
  output logic [3:0]    rx_full,
  output logic [3:0]    rx_empty
);

  localparam int unsigned NSM      = 4;
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    ACT_NOP      = 4'd0,
    ACT_IMEM_WR  = 4'd1,
    ACT_CLKDIV   = 4'd2,
    ACT_PINCTRL  = 4'd3,
    ACT_SM_EN    = 4'd4,
    ACT_RESTART  = 4'd5,
    ACT_TX_PUSH  = 4'd6,
    ACT_RX_POP   = 4'd7,
    ACT_READBACK = 4'd15
  } action_e;

  action_e act;
  assign act = action_e'(action);

  logic [15:0]   imem_q [32];
  logic [15:0]   imem_data_q;
  logic [31:0]   dout_q;
  logic [31:0]   clkdiv_q  [NSM];
  logic [31:0]   pinctrl_q [NSM];
  logic [3:0]    sm_en_q, sm_restart_q;

  logic [31:0]   tx_mem_q [NSM][FIFO_DEPTH];
  logic [31:0]   rx_mem_q [NSM][FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q [NSM];
  logic [PW-1:0] tx_rp_q [NSM];
  logic [PW-1:0] rx_wp_q [NSM];
  logic [PW-1:0] rx_rp_q [NSM];
  logic [PW:0]   tx_cnt_q [NSM];
  logic [PW:0]   rx_cnt_q [NSM];

  logic [NSM-1:0] tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
  logic [NSM-1:0] tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;
  logic [31:0]    rx_head_c [NSM];

  // A push into a full FIFO is only accepted when the same FIFO pops this cycle.
  always_comb begin
    tx_full_c  = '0;
    tx_empty_c = '0;
    rx_full_c  = '0;
    rx_empty_c = '0;
    tx_push_c  = '0;
    tx_pop_c   = '0;
    rx_push_c  = '0;
    rx_pop_c   = '0;
    tx_data    = '0;
    clkdiv     = '0;
    pinctrl    = '0;
    for (int unsigned m = 0; m < NSM; m++) begin
      rx_head_c[m]       = rx_mem_q[m][rx_rp_q[m]];
      tx_data[32*m +: 32] = tx_mem_q[m][tx_rp_q[m]];
      clkdiv[32*m +: 32]  = clkdiv_q[m];
      pinctrl[32*m +: 32] = pinctrl_q[m];
      tx_full_c[m]  = (tx_cnt_q[m] == CNT_FULL);
      tx_empty_c[m] = (tx_cnt_q[m] == '0);
      rx_full_c[m]  = (rx_cnt_q[m] == CNT_FULL);
      rx_empty_c[m] = (rx_cnt_q[m] == '0);
      tx_pop_c[m]   = tx_pull[m] && !tx_empty_c[m];
      tx_push_c[m]  = (act == ACT_TX_PUSH) && (32'(mindex) == m) &&
                      (!tx_full_c[m] || tx_pop_c[m]);
      rx_pop_c[m]   = (act == ACT_RX_POP) && (32'(mindex) == m) && !rx_empty_c[m];
      rx_push_c[m]  = rx_push[m] && (!rx_full_c[m] || rx_pop_c[m]);
    end
  end

  // Instruction memory keeps its contents across reset.
  always_ff @(posedge clk_25mhz) begin
    if (!reset && act == ACT_IMEM_WR) begin
      imem_q[index] <= din[15:0];
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      dout_q       <= '0;
      imem_data_q  <= '0;
      sm_en_q      <= '0;
      sm_restart_q <= '0;
      for (int unsigned m = 0; m < NSM; m++) begin
        clkdiv_q[m]  <= 32'h0001_0000;
        pinctrl_q[m] <= '0;
        tx_wp_q[m]   <= '0;
        tx_rp_q[m]   <= '0;
        tx_cnt_q[m]  <= '0;
        rx_wp_q[m]   <= '0;
        rx_rp_q[m]   <= '0;
        rx_cnt_q[m]  <= '0;
      end
    end else begin
      imem_data_q  <= imem_q[imem_addr];
      sm_restart_q <= '0;
      case (act)
        ACT_CLKDIV:  clkdiv_q[mindex]  <= din;
        ACT_PINCTRL: pinctrl_q[mindex] <= din;
        ACT_SM_EN:   sm_en_q           <= din[3:0];
        ACT_RESTART: sm_restart_q      <= din[3:0];
        ACT_RX_POP: begin
          if (!rx_empty_c[mindex]) dout_q <= rx_head_c[mindex];
        end
`ifdef PIO_HOST_READBACK_EN
        ACT_READBACK: begin
          case (din[1:0])
            2'd0:    dout_q <= {16'h0, imem_q[index]};
            2'd1:    dout_q <= clkdiv_q[mindex];
            2'd2:    dout_q <= pinctrl_q[mindex];
            default: dout_q <= {24'h0, tx_full_c, rx_empty_c};
          endcase
        end
`endif
        default: ;
      endcase
      for (int unsigned m = 0; m < NSM; m++) begin
        if (tx_push_c[m]) begin
          tx_mem_q[m][tx_wp_q[m]] <= din;
          tx_wp_q[m]              <= tx_wp_q[m] + 1'b1;
        end
        if (tx_pop_c[m]) tx_rp_q[m] <= tx_rp_q[m] + 1'b1;
        case ({tx_push_c[m], tx_pop_c[m]})
          2'b10:   tx_cnt_q[m] <= tx_cnt_q[m] + 1'b1;
          2'b01:   tx_cnt_q[m] <= tx_cnt_q[m] - 1'b1;
          default: ;
        endcase
        if (rx_push_c[m]) begin
          rx_mem_q[m][rx_wp_q[m]] <= rx_data[32*m +: 32];
          rx_wp_q[m]              <= rx_wp_q[m] + 1'b1;
        end
        if (rx_pop_c[m]) rx_rp_q[m] <= rx_rp_q[m] + 1'b1;
        case ({rx_push_c[m], rx_pop_c[m]})
          2'b10:   rx_cnt_q[m] <= rx_cnt_q[m] + 1'b1;
          2'b01:   rx_cnt_q[m] <= rx_cnt_q[m] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign imem_data  = imem_data_q;
  assign sm_en      = sm_en_q;
  assign sm_restart = sm_restart_q;
  assign tx_full    = tx_full_c;
  assign tx_empty   = tx_empty_c;
  assign rx_full    = rx_full_c;
  assign rx_empty   = rx_empty_c;

endmodule
